// File: rtl/vec_lsu_pkg.sv
// vec_lsu_pkg: shared state encoding, tag width and lane-index sizing helper
// for the vector load/store unit.
package vec_lsu_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} vlsu_state_t;

    localparam int REG_TAG_W = 5;

    // Width of a lane index; never below one bit so degenerate configs still elaborate.
    function automatic int lane_idx_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/vec_lsu_if.sv
// vec_lsu_if: request / memory / response bundle of the vector load/store unit.
// The slave modport is the LSU side, the master modport is the pipeline +
// data-memory side. VEC_LSU_MASK_EN adds the per-lane req_mask input.
interface vec_lsu_if #(
    parameter int LANES  = 4,
    parameter int LANE_W = 32,
    parameter int ELEM_W = 8,
    parameter int ADDR_W = 32
) ();

    logic                                req_valid;
    logic                                req_ready;
    logic                                req_write;
    logic [ADDR_W-1:0]                   req_addr;
    logic [ADDR_W-1:0]                   req_stride;
    logic [LANES*LANE_W-1:0]             req_wdata;
    logic [vec_lsu_pkg::REG_TAG_W-1:0]   req_rd;
`ifdef VEC_LSU_MASK_EN
    logic [LANES-1:0]                    req_mask;
`endif
    logic                                mem_we;
    logic [ADDR_W-1:0]                   mem_addr;
    logic [ELEM_W-1:0]                   mem_wdata;
    logic [ELEM_W-1:0]                   mem_rdata;
    logic                                resp_valid;
    logic [vec_lsu_pkg::REG_TAG_W-1:0]   resp_rd;
    logic [LANES*LANE_W-1:0]             resp_data;
    logic                                busy;

    modport slave (
        input  req_valid, req_write, req_addr, req_stride, req_wdata, req_rd,
`ifdef VEC_LSU_MASK_EN
        input  req_mask,
`endif
        input  mem_rdata,
        output req_ready, mem_we, mem_addr, mem_wdata,
        output resp_valid, resp_rd, resp_data, busy
    );

    modport master (
        output req_valid, req_write, req_addr, req_stride, req_wdata, req_rd,
`ifdef VEC_LSU_MASK_EN
        output req_mask,
`endif
        output mem_rdata,
        input  req_ready, mem_we, mem_addr, mem_wdata,
        input  resp_valid, resp_rd, resp_data, busy
    );

endinterface

// File: rtl/vec_lsu_lat_pipe.sv
// vec_lsu_lat_pipe: MEM_LAT-deep shift line of {valid, lane index}. The tag
// leaves the line in the same cycle its read data is on mem_rdata.
module vec_lsu_lat_pipe #(
    parameter int MEM_LAT = 1,
    parameter int IDX_W   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx
);

    logic [MEM_LAT-1:0]       valid_q;
    logic [MEM_LAT*IDX_W-1:0] idx_q;

    // Shift tags one stage per cycle; reset drops every in-flight tag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            idx_q   <= '0;
        end else begin
            valid_q <= MEM_LAT'({valid_q, in_valid});
            idx_q   <= (MEM_LAT*IDX_W)'({idx_q, in_idx});
        end
    end

    assign out_valid = valid_q[MEM_LAT-1];
    assign out_idx   = idx_q[(MEM_LAT-1)*IDX_W +: IDX_W];

endmodule

// File: rtl/vec_lsu.sv
// vec_lsu: strided vector load/store unit for the MEM stage. Serialises one
// element per cycle (lane 0 first) to an element-wide data memory and returns
// loads as a zero-extended LANES*LANE_W vector.
// Optional build macro: VEC_LSU_MASK_EN (per-lane request mask).
module vec_lsu
    import vec_lsu_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int LANE_W  = 32,
    parameter int ELEM_W  = 8,
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic     clk,
    input  logic     rst,
    vec_lsu_if.slave bus
);

    localparam int               IDX_W     = lane_idx_w(LANES);
    localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(LANES - 1);

    vlsu_state_t             state_q, state_d;
    logic [IDX_W-1:0]        lane_q;
    logic [ADDR_W-1:0]       addr_q, stride_q;
    logic [LANES*LANE_W-1:0] wdata_q, rbuf_q, rbuf_d, resp_data_q;
    logic [REG_TAG_W-1:0]    rd_q, resp_rd_q;
    logic                    write_q;
    logic [LANES-1:0]        mask_q;
    logic                    accept, issue, drain_done, lane_on;
    logic [ELEM_W-1:0]       lane_wdata;
    logic                    pipe_valid;
    logic [IDX_W-1:0]        pipe_idx;
    logic                    req_ready, busy, mem_we, resp_valid;
    logic [ADDR_W-1:0]       mem_addr;
    logic [ELEM_W-1:0]       mem_wdata;

    vec_lsu_lat_pipe #(
        .MEM_LAT (MEM_LAT),
        .IDX_W   (IDX_W)
    ) u_lat_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (issue && !write_q),
        .in_idx    (lane_q),
        .out_valid (pipe_valid),
        .out_idx   (pipe_idx)
    );

    assign drain_done = pipe_valid && (pipe_idx == LAST_LANE);

    // Lane select: store byte / mask bit of the issuing lane, and merge of the returning read.
    always_comb begin
        lane_wdata = '0;
        lane_on    = 1'b0;
        rbuf_d     = rbuf_q;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (lane_q == IDX_W'(i)) begin
                lane_wdata = wdata_q[i*LANE_W +: ELEM_W];
                lane_on    = mask_q[i];
            end
            if (pipe_valid && (pipe_idx == IDX_W'(i)) && mask_q[i]) begin
                rbuf_d[i*LANE_W +: LANE_W] = LANE_W'(bus.mem_rdata);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // FSM next state and memory/handshake outputs.
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        busy       = 1'b1;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        issue      = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                issue     = 1'b1;
                mem_addr  = addr_q;
                mem_we    = write_q && lane_on;
                mem_wdata = write_q ? lane_wdata : '0;
                if (lane_q == LAST_LANE) state_d = write_q ? IDLE : DRAIN;
            end
            DRAIN: begin
                if (drain_done) state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latch, address walk, load buffer and response registers.
    // resp_data is loaded from the merged buffer so the last lane lands in the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane_q      <= '0;
            addr_q      <= '0;
            stride_q    <= '0;
            wdata_q     <= '0;
            rd_q        <= '0;
            write_q     <= 1'b0;
            rbuf_q      <= '0;
            resp_data_q <= '0;
            resp_rd_q   <= '0;
        end else if (accept) begin
            lane_q   <= '0;
            addr_q   <= bus.req_addr;
            stride_q <= bus.req_stride;
            wdata_q  <= bus.req_wdata;
            rd_q     <= bus.req_rd;
            write_q  <= bus.req_write;
            if (!bus.req_write) rbuf_q <= '0;
        end else begin
            if (issue) begin
                addr_q <= addr_q + stride_q;
                lane_q <= (lane_q == LAST_LANE) ? '0 : lane_q + IDX_W'(1);
            end
            rbuf_q <= rbuf_d;
            if ((state_q == DRAIN) && drain_done) begin
                resp_data_q <= rbuf_d;
                resp_rd_q   <= rd_q;
            end
        end
    end

`ifdef VEC_LSU_MASK_EN
    // Lane mask captured with the request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        mask_q <= '1;
        else if (accept) mask_q <= bus.req_mask;
    end
`else
    assign mask_q = '1;
`endif

    assign bus.req_ready  = req_ready;
    assign bus.busy       = busy;
    assign bus.mem_we     = mem_we;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_wdata  = mem_wdata;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_rd    = resp_rd_q;
    assign bus.resp_data  = resp_data_q;

endmodule
